pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32I core. It drives the `keep`/`nop` controls of the decode stage, plus the PC and IF/ID hold/flush controls, so the pipeline stalls on load-use hazards, freezes while data memory is busy, and squashes wrong-path instructions after a taken branch or jump. It sits beside `decode` and owns all stall/flush policy; the stage registers only obey its outputs. A free-running stall counter is exported for performance measurement.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 60 ++++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, memory-op and opcode constants, control bundle and the
// per-opcode source-register usage helpers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PHC_RUN   = 2'b00,
        PHC_LU    = 2'b01,
        PHC_FLUSH = 2'b10,
        PHC_MEMW  = 2'b11
    } phc_state_e;

    localparam logic [1:0] MEMRW_LOAD = 2'b10;

    // Flush counter width: FLUSH_CYC is limited to 1..7.
    localparam int FCNT_W = 3;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BRA   = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    // Control bundle driven towards PC, IF/ID and ID/EX.
    typedef struct packed {
        logic pc_keep;
        logic ifid_keep;
        logic ifid_nop;
        logic keep;
        logic nop;
    } phc_ctrl_t;

    localparam phc_ctrl_t CTRL_IDLE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam phc_ctrl_t CTRL_FREEZE = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam phc_ctrl_t CTRL_SQUASH = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam phc_ctrl_t CTRL_LU     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    // rs1 is read by every known opcode except the U-type pair and JAL;
    // unknown opcodes are treated as reading nothing.
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_JALR, OP_BRA, OP_LOAD, OP_STORE, OP_IMM, OP_R: uses_rs1 = 1'b1;
            default:                                          uses_rs1 = 1'b0;
        endcase
    endfunction

    // rs2 is only a real operand for R-type, branches and stores; in
    // I-type encodings the same bits are immediate.
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_BRA, OP_STORE, OP_R: uses_rs2 = 1'b1;
            default:                uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: flags when the load in ID/EX
// writes a register that the instruction in IF/ID actually reads.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic [1:0]  ex_memrw,
    input  logic [4:0]  ex_wreg,
    output logic        lu_hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // funct/rd/immediate bits play no part in the hazard decision.
    assign unused_bits = ^{id_instr[31:25], id_instr[14:7]};

    assign rs1_hit = uses_rs1(opcode) && (rs1 == ex_wreg);
    assign rs2_hit = uses_rs2(opcode) && (rs2 == ex_wreg);

    // x0 is never a real dependency even if a load targets it.
    assign lu_hazard = (ex_memrw == MEMRW_LOAD) && (ex_wreg != 5'd0) &&
                       (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: owns stall/flush policy for PC, IF/ID
// and ID/EX. Outputs are Mealy so stage registers react on the next edge.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic [1:0]       ex_memrw,
    input  logic [4:0]       ex_wreg,
    input  logic             br_taken,
    input  logic             dmem_busy,
    output logic             pc_keep,
    output logic             ifid_keep,
    output logic             ifid_nop,
    output logic             keep,
    output logic             nop,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_dbg
);

    localparam logic [FCNT_W-1:0] FLUSH_RELOAD = FCNT_W'(FLUSH_CYC - 1);
    localparam phc_state_e        BR_NEXT      = (FLUSH_CYC == 1) ? PHC_RUN : PHC_FLUSH;

    phc_state_e        state_q, state_d;
    phc_state_e        resume_q, resume_d;
    phc_state_e        eff_state;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    phc_ctrl_t         ctrl;
    logic              lu_hazard;

    load_use_detect u_lud (
        .id_instr  (id_instr),
        .ex_memrw  (ex_memrw),
        .ex_wreg   (ex_wreg),
        .lu_hazard (lu_hazard)
    );

    // Next-state and control decode. Leaving MEM_WAIT (busy just dropped)
    // behaves exactly like the remembered resume state, so a branch held
    // by the frozen stage is acted on in that same cycle.
    always_comb begin
        ctrl      = CTRL_IDLE;
        state_d   = state_q;
        resume_d  = resume_q;
        fcnt_d    = fcnt_q;
        eff_state = state_q;

        if (state_q == PHC_MEMW && !dmem_busy) begin
            eff_state = resume_q;
        end

        if (dmem_busy) begin
            ctrl    = CTRL_FREEZE;
            state_d = PHC_MEMW;
            // Capture where to go back to only on entry; the flush count
            // is left untouched so an interrupted flush resumes intact.
            if (state_q != PHC_MEMW) begin
                resume_d = (state_q == PHC_FLUSH) ? PHC_FLUSH : PHC_RUN;
            end
        end else if (br_taken) begin
            ctrl     = CTRL_SQUASH;
            fcnt_d   = FLUSH_RELOAD;
            state_d  = BR_NEXT;
            resume_d = PHC_RUN;
        end else if (eff_state == PHC_FLUSH && fcnt_q != '0) begin
            ctrl     = CTRL_SQUASH;
            fcnt_d   = fcnt_q - FCNT_W'(1);
            state_d  = (fcnt_q == FCNT_W'(1)) ? PHC_RUN : PHC_FLUSH;
            resume_d = PHC_RUN;
        end else if (lu_hazard && eff_state != PHC_LU) begin
            // One bubble per load-use pair; the cycle after the bubble the
            // load has moved on, so LU_STALL never inserts a second one.
            ctrl     = CTRL_LU;
            state_d  = PHC_LU;
            resume_d = PHC_RUN;
        end else begin
            state_d  = PHC_RUN;
            resume_d = PHC_RUN;
        end

        // Controls are quiet while reset is held.
        if (rst) begin
            ctrl = CTRL_IDLE;
        end
    end

    // Stall performance counter: counts every PC-hold cycle, wraps freely.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_keep) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, flush counter, resume target and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PHC_RUN;
            resume_q    <= PHC_RUN;
            fcnt_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            resume_q    <= resume_d;
            fcnt_q      <= fcnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_keep   = ctrl.pc_keep;
    assign ifid_keep = ctrl.ifid_keep;
    assign ifid_nop  = ctrl.ifid_nop;
    assign keep      = ctrl.keep;
    assign nop       = ctrl.nop;
    assign stall_cnt = stall_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. A 3-bit stall counter is used so
// the wrap from all-ones to zero is reached within the sequence.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 3;

    // Instruction encodings
    localparam logic [31:0] I_ADD     = 32'h00728333; // add x6,x5,x7  (rs1=x5)
    localparam logic [31:0] I_ADD_RS2 = 32'h00538333; // add x6,x7,x5  (rs2=x5)
    localparam logic [31:0] I_ADD_X0  = 32'h00700333; // add x6,x0,x7
    localparam logic [31:0] I_ADDI    = 32'h00538313; // addi x6,x7,5  (imm bits = 5)
    localparam logic [31:0] I_LUI     = 32'h123452B7; // lui x5,0x12345 (rs1 field=8)
    localparam logic [31:0] I_UNK     = 32'h0002807F; // unknown opcode, rs1 field=5

    // Expected control vector {pc_keep, ifid_keep, ifid_nop, keep, nop}
    localparam logic [4:0] O_IDLE   = 5'b00000;
    localparam logic [4:0] O_LU     = 5'b11001;
    localparam logic [4:0] O_FREEZE = 5'b11010;
    localparam logic [4:0] O_SQUASH = 5'b00101;

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_LU  = 2'b01;
    localparam logic [1:0] S_FL  = 2'b10;
    localparam logic [1:0] S_MW  = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      id_instr;
    logic [1:0]       ex_memrw;
    logic [4:0]       ex_wreg;
    logic             br_taken;
    logic             dmem_busy;
    logic             pc_keep, ifid_keep, ifid_nop, keep, nop;
    logic [CNT_W-1:0] stall_cnt;
    logic [1:0]       state_dbg;

    int checks = 0;
    int passes = 0;

    pipe_hazard_ctrl #(.FLUSH_CYC(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .id_instr  (id_instr),
        .ex_memrw  (ex_memrw),
        .ex_wreg   (ex_wreg),
        .br_taken  (br_taken),
        .dmem_busy (dmem_busy),
        .pc_keep   (pc_keep),
        .ifid_keep (ifid_keep),
        .ifid_nop  (ifid_nop),
        .keep      (keep),
        .nop       (nop),
        .stall_cnt (stall_cnt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven; check at negedge, then step past posedge.
    task automatic cyc(input string tag, input logic [4:0] eo, input logic [1:0] es,
                       input logic [CNT_W-1:0] ec);
        @(negedge clk);
        chk({tag, "/ctrl"},  {27'd0, pc_keep, ifid_keep, ifid_nop, keep, nop}, {27'd0, eo});
        chk({tag, "/state"}, {30'd0, state_dbg}, {30'd0, es});
        chk({tag, "/cnt"},   {29'd0, stall_cnt}, {29'd0, ec});
        chk({tag, "/inv"},   {30'd0, keep & nop, ifid_keep & ifid_nop}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; id_instr = '0; ex_memrw = '0; ex_wreg = '0;
        br_taken = 1'b0; dmem_busy = 1'b0;
        @(posedge clk); #1;
        cyc("reset_hold", O_IDLE, S_RUN, 3'd0);
        rst = 1'b0;
        cyc("idle", O_IDLE, S_RUN, 3'd0);

        // Load-use through rs1: one bubble, then the load has advanced
        ex_memrw = 2'b10; ex_wreg = 5'd5; id_instr = I_ADD;
        cyc("lu_rs1", O_LU, S_RUN, 3'd0);
        ex_memrw = 2'b00; ex_wreg = 5'd0;
        cyc("lu_rs1_after", O_IDLE, S_LU, 3'd1);

        // Non-hazards
        ex_memrw = 2'b10; ex_wreg = 5'd8; id_instr = I_LUI;
        cyc("lui_no_rs1", O_IDLE, S_RUN, 3'd1);
        ex_wreg = 5'd0; id_instr = I_ADD_X0;
        cyc("x0_dest", O_IDLE, S_RUN, 3'd1);
        ex_wreg = 5'd5; id_instr = I_ADDI;
        cyc("itype_imm_not_rs2", O_IDLE, S_RUN, 3'd1);
        ex_memrw = 2'b01; id_instr = I_ADD;
        cyc("store_not_load", O_IDLE, S_RUN, 3'd1);
        ex_memrw = 2'b10; id_instr = I_UNK;
        cyc("unknown_op", O_IDLE, S_RUN, 3'd1);

        // Load-use through rs2
        id_instr = I_ADD_RS2;
        cyc("lu_rs2", O_LU, S_RUN, 3'd1);
        ex_memrw = 2'b00; ex_wreg = 5'd0;
        cyc("lu_rs2_after", O_IDLE, S_LU, 3'd2);

        // Branch redirect: two squash cycles
        id_instr = '0;
        br_taken = 1'b1;
        cyc("br_c0", O_SQUASH, S_RUN, 3'd2);
        br_taken = 1'b0;
        cyc("br_c1", O_SQUASH, S_FL, 3'd2);
        cyc("br_done", O_IDLE, S_RUN, 3'd2);

        // Memory freeze for 3 cycles over a load-use pair, then the bubble
        ex_memrw = 2'b10; ex_wreg = 5'd5; id_instr = I_ADD; dmem_busy = 1'b1;
        cyc("mw_c0", O_FREEZE, S_RUN, 3'd2);
        cyc("mw_c1", O_FREEZE, S_MW, 3'd3);
        cyc("mw_c2", O_FREEZE, S_MW, 3'd4);
        dmem_busy = 1'b0;
        cyc("mw_lu", O_LU, S_MW, 3'd5);
        ex_memrw = 2'b00; ex_wreg = 5'd0; id_instr = '0;
        cyc("mw_lu_after", O_IDLE, S_LU, 3'd6);

        // Branch and busy together: freeze first, then flush
        br_taken = 1'b1; dmem_busy = 1'b1;
        cyc("brmw_freeze", O_FREEZE, S_RUN, 3'd6);
        dmem_busy = 1'b0;
        cyc("brmw_br", O_SQUASH, S_MW, 3'd7);
        br_taken = 1'b0;
        cyc("brmw_fl", O_SQUASH, S_FL, 3'd7);
        cyc("brmw_done", O_IDLE, S_RUN, 3'd7);

        // Busy during FLUSH: remaining squash resumes afterwards; counter wraps
        br_taken = 1'b1;
        cyc("flmw_br", O_SQUASH, S_RUN, 3'd7);
        br_taken = 1'b0; dmem_busy = 1'b1;
        cyc("flmw_freeze", O_FREEZE, S_FL, 3'd7);
        dmem_busy = 1'b0;
        cyc("flmw_resume", O_SQUASH, S_MW, 3'd0);
        cyc("flmw_done", O_IDLE, S_RUN, 3'd0);

        // Reset in the second flush cycle
        dmem_busy = 1'b1;
        cyc("pre_rst_busy", O_FREEZE, S_RUN, 3'd0);
        dmem_busy = 1'b0;
        cyc("pre_rst_exit", O_IDLE, S_MW, 3'd1);
        br_taken = 1'b1;
        cyc("rst_br", O_SQUASH, S_RUN, 3'd1);
        br_taken = 1'b0; rst = 1'b1; dmem_busy = 1'b1;
        cyc("rst_in_flush", O_IDLE, S_FL, 3'd1);
        rst = 1'b0; dmem_busy = 1'b0;
        cyc("after_rst", O_IDLE, S_RUN, 3'd0);
        cyc("after_rst2", O_IDLE, S_RUN, 3'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
